// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier.
//   mul_state_t       : controller state encoding
//   MUL_DEFAULT_WIDTH : default operand width in bits
package mul_pkg;

    localparam int MUL_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/product handshake bundle for the shift-add multiplier.
//   in_valid/in_ready           : operand handshake
//   multiplicand/multiplier     : unsigned operands M and Q
//   abort                       : synchronous cancel
//   out_valid/out_ready/product : result handshake, product is 2*WIDTH bits
//   busy                        : block is in CALC or DONE
// master drives operands and consumes the product; slave is the multiplier.
interface shift_add_multiplier_if import mul_pkg::*; #(
    parameter int WIDTH = MUL_DEFAULT_WIDTH
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 abort;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, multiplicand, multiplier, abort, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, abort, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/multiplication_datapath.sv
// A/Q/M registers and the shift-add adder of the sequential multiplier.
//   clk, reset_n : clock and asynchronous active-low reset
//   load_i       : latch M and Q, clear A
//   step_i       : one add-then-shift-right step over {A, Q}
//   clear_i      : clear A and Q (abort); M is left as is
//   m_i, q_i     : operands captured on load_i
//   product_o    : {A[WIDTH-1:0], Q}, straight from registers
module multiplication_datapath import mul_pkg::*; #(
    parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 clear_i,
    input  logic [WIDTH-1:0]     m_i,
    input  logic [WIDTH-1:0]     q_i,
    output logic [2*WIDTH-1:0]   product_o
);

    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            q_q <= '0;
            m_q <= '0;
        end else begin
            a_q <= a_d;
            q_q <= q_d;
            m_q <= m_d;
        end
    end

    always_comb begin
        // A[WIDTH] is always zero after a shift, so adding the full A is the
        // same as adding A[WIDTH-1:0]; the carry lands in sum[WIDTH].
        sum = a_q + (q_q[0] ? {1'b0, m_q} : '0);
        a_d = a_q;
        q_d = q_q;
        m_d = m_q;
        if (clear_i) begin
            a_d = '0;
            q_d = '0;
        end else if (load_i) begin
            a_d = '0;
            q_d = q_i;
            m_d = m_i;
        end else if (step_i) begin
            // {sum, Q} >> 1: sum's LSB moves into the top of Q
            a_d = {1'b0, sum[WIDTH:1]};
            q_d = {sum[0], q_q[WIDTH-1:1]};
        end
    end

    assign product_o = {a_q[WIDTH-1:0], q_q};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: WIDTH shift-add steps per product.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus (slave)  : operand handshake, abort, product handshake, busy
//
//   state | meaning
//   ------+-------------------------------------------------
//   IDLE  | in_ready high, waiting for an operand pair
//   CALC  | one shift-add step per clock, WIDTH steps total
//   DONE  | product valid, waiting for out_ready
module shift_add_multiplier import mul_pkg::*; #(
    parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    shift_add_multiplier_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    mul_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             load, step, clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        step        = 1'b0;
        clear       = 1'b0;
        // abort beats both an accept in IDLE and a transfer in DONE
        if (bus.abort) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            clear       = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        load    = 1'b1;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;

    multiplication_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (load),
        .step_i    (step),
        .clear_i   (clear),
        .m_i       (bus.multiplicand),
        .q_i       (bus.multiplier),
        .product_o (bus.product)
    );

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;
    import mul_pkg::*;

    localparam int W  = MUL_DEFAULT_WIDTH;
    localparam int PW = 2 * W;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    shift_add_multiplier_if #(.WIDTH(W)) bus ();

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [PW-1:0] exp_q[$];
    mul_state_t    m_state = IDLE;
    int            m_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input int unsigned m, input int unsigned q);
        return PW'(m * q);
    endfunction

    // Advance one clock. The bench's own state model decides accepts and
    // transfers from the inputs it is about to present, then checks the
    // handshake outputs #1 after the edge.
    task automatic tick();
        logic aborted;
        aborted = bus.abort;
        if (bus.abort) begin
            m_state = IDLE;
            exp_q.delete();
        end else begin
            case (m_state)
                IDLE: if (bus.in_valid) begin
                    exp_q.push_back(ref_mul(bus.multiplicand, bus.multiplier));
                    m_state = CALC;
                    m_cnt   = 0;
                end
                CALC: if (m_cnt == W - 1) m_state = DONE; else m_cnt++;
                DONE: if (bus.out_ready) begin
                    if (exp_q.size() > 0) check("product", bus.product, exp_q.pop_front());
                    m_state = IDLE;
                end
                default: m_state = IDLE;
            endcase
        end
        @(posedge clk); #1;
        check("in_ready",  bus.in_ready,  m_state == IDLE);
        check("out_valid", bus.out_valid, m_state == DONE);
        check("busy",      bus.busy,      m_state != IDLE);
        if (aborted) check("product_after_abort", bus.product, 0);
    endtask

    task automatic run_op(input int m, input int q);
        bus.multiplicand = W'(m);
        bus.multiplier   = W'(q);
        bus.in_valid     = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3 * W && m_state != IDLE; i++) tick();
    endtask

    initial begin
        int lat;
        int n_low;
        int edges;
        int k;
        int cyc;

        reset_n          = 1'b0;
        bus.in_valid     = 1'b0;
        bus.abort        = 1'b0;
        bus.out_ready    = 1'b1;
        bus.multiplicand = '0;
        bus.multiplier   = '0;

        // reset state, before any clock edge
        #3;
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy",      bus.busy,      0);
        check("rst_product",   bus.product,   0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();

        // 13*11: out_valid on the 4th edge after accept; in_ready low for the
        // 5 cycles following the accept cycle (6 cycles including it)
        bus.multiplicand = W'(13);
        bus.multiplier   = W'(11);
        bus.in_valid     = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat   = -1;
        n_low = 0;
        edges = 0;
        while (!bus.in_ready && edges < 20) begin
            n_low++;
            if (bus.out_valid && lat < 0) lat = edges;
            tick();
            edges++;
        end
        check("t1_latency",      lat,   W);
        check("t1_in_ready_low", n_low, W + 1);

        // extremes and zero operands
        run_op(15, 15);
        run_op(0, 9);
        run_op(9, 0);

        // back-pressure: 6*7 held for 5 cycles with out_ready low
        bus.out_ready    = 1'b0;
        bus.multiplicand = W'(6);
        bus.multiplier   = W'(7);
        bus.in_valid     = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3 * W && m_state != DONE; i++) tick();
        repeat (5) begin
            check("hold_product", bus.product, 42);
            tick();
        end
        check("hold_product", bus.product, 42);
        bus.out_ready = 1'b1;
        tick();
        check("idle_product_retained", bus.product, 42);
        tick();

        // asynchronous reset after two CALC steps of 12*5
        bus.multiplicand = W'(12);
        bus.multiplier   = W'(5);
        bus.in_valid     = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_busy",      bus.busy,      0);
        check("async_rst_in_ready",  bus.in_ready,  1);
        check("async_rst_product",   bus.product,   0);
        m_state = IDLE;
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_held_out_valid", bus.out_valid, 0);
        reset_n = 1'b1;
        tick();
        run_op(12, 5);

        // abort in the first CALC step of 10*10
        bus.multiplicand = W'(10);
        bus.multiplier   = W'(10);
        bus.in_valid     = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.abort    = 1'b1;
        tick();
        bus.abort = 1'b0;
        repeat (W + 2) tick();
        check("abort_product_stays_zero", bus.product, 0);
        run_op(7, 6);

        // abort beats an accept in IDLE
        bus.multiplicand = W'(3);
        bus.multiplier   = W'(3);
        bus.in_valid     = 1'b1;
        bus.abort        = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        tick();

        // abort beats a transfer in DONE
        bus.out_ready    = 1'b0;
        bus.multiplicand = W'(2);
        bus.multiplier   = W'(3);
        bus.in_valid     = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3 * W && m_state != DONE; i++) tick();
        bus.out_ready = 1'b1;
        bus.abort     = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();

        // in_valid held high with fresh operands every cycle: only the
        // pairs present while IDLE are taken (3*4 then 5*5)
        k   = 0;
        cyc = 0;
        bus.in_valid = 1'b1;
        while (!(k == 2 && m_state == IDLE) && cyc < 40) begin
            if (m_state == IDLE) begin
                bus.multiplicand = (k == 0) ? W'(3) : W'(5);
                bus.multiplier   = (k == 0) ? W'(4) : W'(5);
                k++;
            end else begin
                bus.multiplicand = W'($urandom_range(0, (1 << W) - 1));
                bus.multiplier   = W'($urandom_range(0, (1 << W) - 1));
            end
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("stream_last_product", bus.product, 25);
        check("stream_cycles", cyc, 2 * (W + 2));
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Sequential unsigned multiplier, the inverse operation of the team's restoring-division datapath.
- Accepts an operand pair over a valid/ready handshake and computes the product with one shift-add step per clock.
- Presents a double-width product over a second valid/ready handshake.
- Sits beside the divider in the ALU; the ALU top-level muxes results from the two blocks.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits; legal values are 2 to 16.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operands are valid
in_ready  output  1  block can accept operands
multiplicand  input  WIDTH  unsigned operand M
multiplier  input  WIDTH  unsigned operand Q
abort  input  1  synchronous cancel of the current operation
out_valid  output  1  product is valid
out_ready  input  1  consumer accepts the product
product  output  2*WIDTH  unsigned M*Q
busy  output  1  high while in CALC or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is asynchronous and active-low. Every register clears on reset_n falling, independent of clk.
- Reset values:
  - state = IDLE, out_valid = 0, busy = 0.
  - product = 0; A, Q, M and count all 0.
  - in_ready = 1 (combinational from state == IDLE).
- Registers:
  - A: WIDTH+1 bits, accumulator with carry.
  - Q: WIDTH bits, multiplier, shifting.
  - M: WIDTH bits, latched multiplicand.
  - count: clog2(WIDTH) bits.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid && in_ready && !abort: latch M, Q; clear A and count; go to CALC.
- CALC, executed once per edge:
  - sum = A[WIDTH-1:0] + (Q[0] ? M : 0), computed in WIDTH+1 bits.
  - {A, Q} <= {sum, Q} >> 1, a logical right shift by one over the 2*WIDTH+1 bits.
  - count increments each edge.
  - On the edge where count == WIDTH-1: go to DONE and set out_valid = 1.
- DONE:
  - product = {A[WIDTH-1:0], Q}, driven from registers (no combinational path from inputs).
  - Held stable while out_valid && !out_ready.
  - On an edge with out_valid && out_ready: out_valid <= 0, go to IDLE.
- Latency and throughput:
  - Accept edge T → out_valid first visible after edge T+WIDTH, i.e. WIDTH cycles of CALC.
  - A new accept is possible no earlier than one cycle after the output handshake completes.
  - Throughput is one result per WIDTH+2 cycles when out_ready is held high.
- Arithmetic: strictly unsigned. The product always fits in 2*WIDTH bits, so there is no overflow flag. The carry into A[WIDTH] is always consumed by the following shift.
- Zero operands: no early exit. All WIDTH steps execute and the result is 0.
- abort:
  - In any state, abort on an edge forces IDLE with out_valid = 0; A, Q and count are cleared.
  - product reads 0 after an abort.
  - abort in IDLE with in_valid high: abort wins, no accept.
  - abort in DONE with out_ready high in the same cycle: abort wins; the transfer is not counted.
- Input stability: operand inputs are ignored outside the accept edge. in_valid held high during CALC/DONE has no effect.
- Reset mid-operation: the computation is discarded. The block restarts in IDLE after reset_n rises; no stale out_valid.
- Output after the handshake: product retains its last value in IDLE and is qualified only by out_valid.

Decomposition:
- Shared package mul_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t.
  - localparam MUL_DEFAULT_WIDTH = 4.
- One natural sub-module, multiplication_datapath, holding the A/Q/M registers and the shift-add adder.
  - Controlled by load, step and clear inputs.
  - Mirrors the divider's datapath/controller split.
- The FSM and handshake stay in shift_add_multiplier.

Test Plan:
1. WIDTH=4, M=13, Q=11, out_ready=1 → out_valid on 4th edge after accept, product=143 (0x8F); in_ready low for exactly 6 cycles including the accept cycle.
2. M=15, Q=15 → product=225 (0xE1); M=0, Q=9 → 0; M=9, Q=0 → 0; each takes 4 CALC cycles.
3. M=6, Q=7, out_ready low for 5 cycles after out_valid → product holds 42 and out_valid holds 1; the transfer completes on the cycle out_ready rises; in_ready returns the next cycle.
4. reset_n pulsed low mid-CALC (after 2 steps) of 12*5 → all outputs zero immediately, asynchronously. After release, 12*5 → 60.
5. abort asserted in CALC step 1 of 10*10 → IDLE next cycle, out_valid never rises, product=0. Then 7*6 → 42.
6. in_valid held high with a new operand pair each cycle, out_ready=1 → only pairs present on IDLE accept edges are processed; results 3*4=12, then 5*5=25 in order; no accept during CALC/DONE.
